mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single 16-bit memory port between the fetch stage (instruction word reads) and the ALU stage (byte/word loads and stores). It sits between those two requesters and the memory bus, replacing the constant read data the ALU stage currently receives. It handles byte lanes, misalignment and memory timeouts. Each requester sees a simple req/ack handshake.

## Interface
- MAX_DATA_STREAK, 4: consecutive data grants allowed while fetch waits before fetch is forced (1..15)
- TIMEOUT, 255: cycles in a memory access without mem_ready before abort (1..255)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch read request; hold with fetch_addr until fetch_ack
- fetch_addr  in  16  byte address of instruction word
- fetch_ack  out  1  one-cycle completion pulse
- fetch_data  out  16  instruction word, valid while fetch_ack
- fetch_err  out  1  with fetch_ack: misaligned or timeout
- data_req  in  1  data request; hold with all data_* inputs until data_ack
- data_we  in  1  1 = store, 0 = load
- data_byte  in  1  1 = byte access, 0 = word
- data_addr  in  16  byte address
- data_wdata  in  16  store data (byte store uses [7:0])
- data_ack  out  1  one-cycle completion pulse
- data_rdata  out  16  load data, valid while data_ack
- data_err  out  1  with data_ack: misaligned or timeout
- mem_req  out  1  memory access in progress
- mem_we  out  1  write strobe
- mem_be  out  2  byte enables {hi, lo}
- mem_addr  out  16  word address, bit 0 always 0
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, sampled with mem_ready
- mem_ready  in  1  memory completes current access this cycle
- dbg_owner  out  2  0 idle, 1 fetch, 2 data

## Operation
- States: IDLE, BUSY, RESP. Registered owner (fetch/data), streak counter (4 bits) and timeout counter (8 bits).
- IDLE, no req: stay.
  - Only one req: grant it.
  - Both: grant data, unless streak == MAX_DATA_STREAK, then grant fetch.
- Streak counter:
  - Increments on a data grant while fetch_req = 1.
  - Clears on any fetch grant, or on a data grant with fetch_req = 0.
- Misaligned access (word with addr[0] = 1; fetch is always word): go IDLE -> RESP with err = 1, no mem_req, rdata 0.
- Otherwise IDLE -> BUSY. Register mem_addr = {addr[15:1], 0}, mem_we and mem_wdata, then assert mem_req.
  - Word access: mem_be = 11.
  - Byte access: mem_be = 10 if addr[0], else 01.
  - Byte store: mem_wdata = {wdata[7:0], wdata[7:0]}.
- BUSY with mem_ready = 1: go to RESP.
  - Capture rdata: word = mem_rdata; byte = {8'h00, selected lane}.
  - err = 0.
- BUSY with mem_ready = 0: timeout counter increments. When it reaches TIMEOUT, go to RESP with err = 1 and rdata 0. The counter clears on entering BUSY.
- RESP: the owner's ack = 1 for exactly one cycle with rdata/err, then go IDLE. No grant is made in RESP, so a req still high during the ack cycle is not re-granted. The requester drops req or presents a new request by the following edge.
- A store completes the same way; rdata = 0.
- data_rdata/fetch_data/err hold their values outside ack; only valid with ack.

## Timing
- Reset (async assert): state IDLE, counters 0. All outputs 0, including mem_req, acks, errs, rdata, mem_* and dbg_owner. A reset during BUSY drops mem_req immediately and issues no ack.
- Request seen in IDLE at edge N: mem_req = 1 from N+1.
- mem_ready sampled high at edge M: mem_req = 0 and ack = 1 during cycle M+1, then IDLE at M+2.
- Zero-wait memory (mem_ready = 1 whenever mem_req): req -> ack latency is 2 cycles, with one access per 3 cycles.
- Misaligned: ack with err in the cycle after the request is seen.
- mem_addr/mem_be/mem_we/mem_wdata are stable for the whole of mem_req. mem_ready is ignored when mem_req = 0.
- Timeout: mem_req stays high for exactly TIMEOUT cycles, then ack+err.
- dbg_owner is nonzero in BUSY and RESP.

## Test plan
- Word load: data_req, addr 0x0010, memory returns 0xBEEF with 0 wait -> data_ack 2 cycles later, data_rdata 0xBEEF, mem_be 11, mem_addr 0x0010.
- Byte ops: byte load addr 0x0011 with mem_rdata 0x12AB -> mem_be 10, data_rdata 0x0012. Byte store 0x00C3 to 0x0020 -> mem_wdata 0xC3C3, mem_be 01, mem_we 1.
- Arbitration/streak (MAX_DATA_STREAK 4): fetch_req and data_req held continuously -> grant order D D D D F D D D D F, and fetch_ack never waits more than 4 data accesses.
- Misaligned: word load at 0x0003 -> data_ack + data_err next cycle, mem_req never asserted, data_rdata 0.
- Timeout (TIMEOUT 8): mem_ready held 0 -> mem_req high 8 cycles, then fetch_ack with fetch_err = 1 and fetch_data 0, then the next request is served normally.
- Reset mid-access: rst_n low during BUSY -> mem_req, acks and dbg_owner 0 immediately. After release, a pending request is granted fresh with streak 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit memory port between instruction fetch and
// data load/store requesters, with byte lanes, misalignment and timeout handling.
module mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_ack,
    output logic [15:0] fetch_data,
    output logic        fetch_err,
    input  logic        data_req,
    input  logic        data_we,
    input  logic        data_byte,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    output logic        data_ack,
    output logic [15:0] data_rdata,
    output logic        data_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  dbg_owner
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_nx;
    logic        own_data, byte_q, hi_lane;
    logic        any_req, sel_data, g_byte, g_we, misal, timed_out, done;
    logic        resp_own, resp_err;
    logic [3:0]  streak;
    logic [7:0]  tcnt;
    logic [15:0] g_addr, resp_rdata;

    always_comb begin
        any_req   = fetch_req | data_req;
        sel_data  = data_req & ~(fetch_req & (streak == 4'(MAX_DATA_STREAK)));
        g_addr    = sel_data ? data_addr : fetch_addr;
        g_byte    = sel_data & data_byte;
        g_we      = sel_data & data_we;
        misal     = ~g_byte & g_addr[0];
        timed_out = tcnt == 8'(TIMEOUT - 1);
        done      = mem_ready | timed_out;
        state_nx  = state;
        case (state)
            IDLE:    if (any_req) state_nx = misal ? RESP : BUSY;
            BUSY:    if (done) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    // A response is either a misaligned reject from IDLE or the end of a BUSY access
    assign resp_own   = (state == IDLE) ? sel_data : own_data;
    assign resp_err   = ~(state == BUSY & mem_ready);
    assign resp_rdata = (resp_err | mem_we) ? 16'h0000 :
                        byte_q ? {8'h00, hi_lane ? mem_rdata[15:8] : mem_rdata[7:0]} : mem_rdata;

    assign fetch_ack = (state == RESP) & ~own_data;
    assign data_ack  = (state == RESP) & own_data;
    assign dbg_owner = (state == IDLE) ? 2'd0 : own_data ? 2'd2 : 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_data   <= 1'b0;
            byte_q     <= 1'b0;
            hi_lane    <= 1'b0;
            streak     <= 4'd0;
            tcnt       <= 8'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 2'b00;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            fetch_data <= 16'h0000;
            fetch_err  <= 1'b0;
            data_rdata <= 16'h0000;
            data_err   <= 1'b0;
        end else begin
            mem_req <= state_nx == BUSY;
            if (state == IDLE && any_req) begin
                own_data  <= sel_data;
                streak    <= (sel_data & fetch_req) ? streak + 4'd1 : 4'd0;
                tcnt      <= 8'd0;
                byte_q    <= g_byte;
                hi_lane   <= g_addr[0];
                mem_we    <= g_we & ~misal;
                mem_be    <= g_byte ? (g_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                mem_addr  <= {g_addr[15:1], 1'b0};
                mem_wdata <= g_byte ? {2{data_wdata[7:0]}} : data_wdata;
            end
            if (state == BUSY && !mem_ready) tcnt <= tcnt + 8'd1;
            if (state == BUSY && done) mem_we <= 1'b0;
            if (state != RESP && state_nx == RESP) begin
                if (resp_own) begin
                    data_rdata <= resp_rdata;
                    data_err   <= resp_err;
                end else begin
                    fetch_data <= resp_rdata;
                    fetch_err  <= resp_err;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level reference model evaluated every cycle.
module tb_mem_arbiter;
    localparam int MAX_DATA_STREAK = 4;
    localparam int TIMEOUT         = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, fetch_ack, fetch_err;
    logic [15:0] fetch_addr, fetch_data;
    logic        data_req, data_we, data_byte, data_ack, data_err;
    logic [15:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [1:0]  mem_be, dbg_owner;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;
    int rdy_pct = 100;

    // Reference model: phase 0 idle, 1 waiting on memory, 2 responding
    int          m_ph, m_streak, m_wait;
    logic        m_dat, m_byte, m_we, m_hi, m_ferr, m_derr;
    logic [1:0]  m_be;
    logic [15:0] m_maddr, m_wdata, m_fdata, m_ddata;

    mem_arbiter #(.MAX_DATA_STREAK(MAX_DATA_STREAK), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_data(fetch_data), .fetch_err(fetch_err),
        .data_req(data_req), .data_we(data_we), .data_byte(data_byte),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_ack(data_ack),
        .data_rdata(data_rdata), .data_err(data_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dbg_owner(dbg_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dut=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_streak = 0; m_wait = 0;
        m_dat = 0; m_byte = 0; m_we = 0; m_hi = 0; m_ferr = 0; m_derr = 0;
        m_be = 0; m_maddr = 0; m_wdata = 0; m_fdata = 0; m_ddata = 0;
    endtask

    task automatic model_respond(input logic [15:0] rd, input logic err);
        m_ph = 2;
        if (m_dat) begin m_ddata = rd; m_derr = err; end
        else begin m_fdata = rd; m_ferr = err; end
    endtask

    // Advance the model by one clock edge using the inputs the DUT is about to sample
    task automatic model_step();
        logic        d;
        logic [15:0] a;
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_ph)
            0: if (fetch_req || data_req) begin
                d        = data_req && !(fetch_req && m_streak == MAX_DATA_STREAK);
                m_streak = (d && fetch_req) ? m_streak + 1 : 0;
                a        = d ? data_addr : fetch_addr;
                m_dat    = d;
                m_byte   = d && data_byte;
                m_we     = d && data_we;
                m_hi     = a[0];
                if (!m_byte && a[0]) model_respond(16'h0000, 1'b1);
                else begin
                    m_ph    = 1;
                    m_wait  = 0;
                    m_maddr = a & 16'hFFFE;
                    m_be    = !m_byte ? 2'b11 : a[0] ? 2'b10 : 2'b01;
                    m_wdata = m_byte ? {data_wdata[7:0], data_wdata[7:0]} : data_wdata;
                end
            end
            1: if (mem_ready) begin
                if (m_we)        model_respond(16'h0000, 1'b0);
                else if (!m_byte) model_respond(mem_rdata, 1'b0);
                else if (m_hi)   model_respond({8'h00, mem_rdata[15:8]}, 1'b0);
                else             model_respond({8'h00, mem_rdata[7:0]}, 1'b0);
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) model_respond(16'h0000, 1'b1);
            end
            default: m_ph = 0;
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("mem_req", 32'(mem_req), 32'(m_ph == 1));
        chk("mem_we", 32'(mem_we), 32'(m_ph == 1 && m_we));
        if (m_ph == 1) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
            chk("mem_be", 32'(mem_be), 32'(m_be));
            if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        end
        chk("fetch_ack", 32'(fetch_ack), 32'(m_ph == 2 && !m_dat));
        chk("data_ack", 32'(data_ack), 32'(m_ph == 2 && m_dat));
        chk("fetch_data", 32'(fetch_data), 32'(m_fdata));
        chk("fetch_err", 32'(fetch_err), 32'(m_ferr));
        chk("data_rdata", 32'(data_rdata), 32'(m_ddata));
        chk("data_err", 32'(data_err), 32'(m_derr));
        chk("dbg_owner", 32'(dbg_owner), m_ph == 0 ? 32'd0 : m_dat ? 32'd2 : 32'd1);
    endtask

    task automatic wait_ack(input logic want_data, input string nm);
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = want_data ? data_ack : fetch_ack;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    // Records owners of the next n grants, first grant in bit 0 (1 = data)
    task automatic run_grants(input int n, output logic [15:0] seq, output int got);
        logic [1:0] prev;
        seq  = '0;
        got  = 0;
        prev = dbg_owner;
        for (int i = 0; i < 100 && got < n; i++) begin
            tick();
            if (prev == 2'd0 && dbg_owner != 2'd0) begin
                seq[got] = dbg_owner == 2'd2;
                got++;
            end
            prev = dbg_owner;
        end
    endtask

    function automatic logic [15:0] rand_addr(input logic odd_ok);
        logic [15:0] a;
        a    = 16'($urandom);
        a[0] = odd_ok ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
        return a;
    endfunction

    task automatic drive_random();
        if (!fetch_req || fetch_ack) begin
            fetch_req  = $urandom_range(0, 99) < 40;
            fetch_addr = rand_addr(1'b0);
        end
        if (!data_req || data_ack) begin
            data_req   = $urandom_range(0, 99) < 40;
            data_we    = 1'($urandom_range(0, 1));
            data_byte  = 1'($urandom_range(0, 1));
            data_addr  = rand_addr(data_byte);
            data_wdata = 16'($urandom);
        end
        mem_ready = $urandom_range(0, 99) < rdy_pct;
        mem_rdata = 16'($urandom);
    endtask

    initial begin
        logic [15:0] seq;
        int          got, cnt;
        rst_n = 0; fetch_req = 0; fetch_addr = 0; data_req = 0; data_we = 0;
        data_byte = 0; data_addr = 0; data_wdata = 0; mem_ready = 0; mem_rdata = 0;
        model_reset();
        repeat (3) tick();
        chk("rst_mem", 32'({mem_req, mem_we, mem_be, mem_addr}), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_resp", 32'({fetch_ack, fetch_err, data_ack, data_err, dbg_owner}), 32'd0);
        chk("rst_rdata", 32'({fetch_data, data_rdata}), 32'd0);
        rst_n = 1;

        // Word load, zero wait
        data_req = 1; data_addr = 16'h0010; mem_ready = 1; mem_rdata = 16'hBEEF;
        tick();
        chk("wl_addr", 32'(mem_addr), 32'h0010);
        chk("wl_be", 32'(mem_be), 32'd3);
        tick();
        chk("wl_ack", 32'(data_ack), 32'd1);
        chk("wl_rdata", 32'(data_rdata), 32'hBEEF);
        data_req = 0;
        tick();
        chk("wl_hold", 32'({data_ack, data_rdata}), 32'h0BEEF);

        // Byte load, high lane
        data_req = 1; data_byte = 1; data_addr = 16'h0011; mem_rdata = 16'h12AB;
        tick();
        chk("bl_be", 32'(mem_be), 32'd2);
        tick();
        chk("bl_rdata", 32'({data_ack, data_rdata}), 32'h10012);
        data_req = 0;
        tick();

        // Byte store, low lane
        data_req = 1; data_we = 1; data_addr = 16'h0020; data_wdata = 16'h00C3;
        tick();
        chk("bs_wdata", 32'(mem_wdata), 32'hC3C3);
        chk("bs_be_we", 32'({mem_be, mem_we}), 32'b011);
        tick();
        chk("bs_ack", 32'({data_ack, data_rdata}), 32'h10000);
        data_req = 0;
        tick();

        // Misaligned word load
        data_req = 1; data_we = 0; data_byte = 0; data_addr = 16'h0003;
        tick();
        chk("mis_ack", 32'({data_ack, data_err, mem_req}), 32'b110);
        chk("mis_rdata", 32'(data_rdata), 32'd0);
        data_req = 0;
        tick();
        chk("mis_noreq", 32'(mem_req), 32'd0);

        // Fetch timeout, then a normal fetch
        fetch_req = 1; fetch_addr = 16'h0100; mem_ready = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fetch_ack) break;
            if (mem_req) cnt++;
        end
        chk("to_cycles", 32'(cnt), 32'(TIMEOUT));
        chk("to_resp", 32'({fetch_ack, fetch_err, fetch_data}), 32'h30000);
        fetch_addr = 16'h0102; mem_ready = 1; mem_rdata = 16'h4321;
        wait_ack(1'b0, "to_next_ack");
        chk("to_next", 32'({fetch_err, fetch_data}), 32'h04321);
        fetch_req = 0;
        tick();

        // Arbitration with both requesters held
        fetch_req = 1; fetch_addr = 16'h0200; data_req = 1; data_addr = 16'h0300;
        run_grants(10, seq, got);
        chk("arb_count", 32'(got), 32'd10);
        chk("arb_order", 32'(seq), 32'h01EF);
        wait_ack(1'b0, "arb_fetch_ack");
        fetch_req = 0; data_req = 0;
        tick();

        // Reset in the middle of a stalled access
        fetch_req = 1; data_req = 1;
        run_grants(2, seq, got);
        chk("rm_pre", 32'(seq[1:0]), 32'b11);
        mem_ready = 0;
        tick();
        tick();
        #2 rst_n = 0;
        #1;
        chk("rm_async", 32'({mem_req, fetch_ack, data_ack, dbg_owner}), 32'd0);
        tick();
        rst_n = 1; mem_ready = 1;
        run_grants(10, seq, got);
        chk("rm_order", 32'(seq), 32'h01EF);
        wait_ack(1'b0, "rm_fetch_ack");
        fetch_req = 0; data_req = 0;
        tick();

        // Randomized traffic at several memory speeds, with resets between blocks
        for (int b = 0; b < 6; b++) begin
            rdy_pct = (b % 3 == 0) ? 80 : (b % 3 == 1) ? 40 : 8;
            for (int i = 0; i < 400; i++) begin
                drive_random();
                tick();
            end
            #3 rst_n = 0;
            tick();
            rst_n = 1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
